// File: rtl/rr_muxnm.sv
// Registered N-channel round-robin arbitrating multiplexer with valid/ready on every port.
// Optional RR_MUXNM_FORCE_EN adds force_en/force_ctrl to pin the grant to one channel.
module rr_muxnm #(
  parameter int bits  = 8,
  parameter int chans = 3,
  parameter int cw    = $clog2(chans)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [chans-1:0]            in_valid,
  input  logic [chans-1:0][bits-1:0]  in_data,
  output logic [chans-1:0]            in_ready,
  output logic                        out_valid,
  output logic [bits-1:0]             out_data,
  output logic [cw-1:0]               out_ch,
  input  logic                        out_ready
`ifdef RR_MUXNM_FORCE_EN
  ,
  input  logic                        force_en,
  input  logic [cw-1:0]               force_ctrl
`endif
);

  logic            out_valid_q;
  logic [bits-1:0] out_data_q;
  logic [cw-1:0]   out_ch_q;
  logic [cw-1:0]   ptr_q, ptr_d;

  logic            accept;
  logic            forced;
  logic            rr_any;
  logic [cw-1:0]   rr_idx;
  logic            gnt_any;
  logic [cw-1:0]   gnt_idx;

  assign accept = !out_valid_q || out_ready;

`ifdef RR_MUXNM_FORCE_EN
  assign forced = force_en;
`else
  assign forced = 1'b0;
`endif

  // Scan from the highest offset down so the last hit is the nearest requester at or after ptr.
  always_comb begin
    int            cand_sum;
    logic [cw-1:0] cand_idx;
    rr_any   = 1'b0;
    rr_idx   = '0;
    cand_sum = 0;
    cand_idx = '0;
    for (int k = chans - 1; k >= 0; k--) begin
      cand_sum = int'(ptr_q) + k;
      if (cand_sum >= chans) begin
        cand_sum = cand_sum - chans;
      end
      cand_idx = cw'(cand_sum);
      if (in_valid[cand_idx]) begin
        rr_any = 1'b1;
        rr_idx = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_any = rr_any;
    gnt_idx = rr_idx;
`ifdef RR_MUXNM_FORCE_EN
    if (force_en) begin
      // An out-of-range force_ctrl matches no channel and so grants nothing.
      gnt_any = 1'b0;
      gnt_idx = force_ctrl;
      for (int i = 0; i < chans; i++) begin
        if (force_ctrl == cw'(i)) begin
          gnt_any = in_valid[i];
        end
      end
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < chans; i++) begin
      in_ready[i] = rst_n && accept && gnt_any && (gnt_idx == cw'(i));
    end
  end

  always_comb begin
    if (forced) begin
      ptr_d = ptr_q;
    end else if (int'(gnt_idx) == chans - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + cw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else if (accept) begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[gnt_idx];
        out_ch_q    <= gnt_idx;
        ptr_q       <= ptr_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
  a_ready_valid  : assert property (@(posedge clk) disable iff (!rst_n)
                                    (in_ready & ~in_valid) == '0);
  a_ch_range     : assert property (@(posedge clk) disable iff (!rst_n) int'(out_ch) < chans);

endmodule
